// File: rtl/ushift_pkg.sv
// ============================================================================
// ushift_pkg : mode codes, FSM state encoding and helpers for universal_shift_reg
// Revision   : 1.0
// ============================================================================
`default_nettype none

package ushift_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_SLL  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SRL  = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SRA  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd5;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Codes 6 and 7 are treated as LOAD.
  function automatic logic is_load(input logic [MODE_W-1:0] mode);
    return (mode >= MODE_LOAD);
  endfunction

  // Shifts (not rotates) discard bits and so feed the sticky accumulator.
  function automatic logic is_lossy(input logic [MODE_W-1:0] mode);
    return (mode <= MODE_SRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ushift_step.sv
// ============================================================================
// ushift_step : combinational single-position shift/rotate of one word
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ushift_step
  import ushift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  word_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              fill_i,
  output logic [WIDTH-1:0]  word_o,
  output logic              out_bit_o
);

  always_comb begin
    word_o    = word_i;
    out_bit_o = 1'b0;
    case (mode_i)
      MODE_SLL: begin
        word_o    = {word_i[WIDTH-2:0], fill_i};
        out_bit_o = word_i[WIDTH-1];
      end
      MODE_SRL: begin
        word_o    = {fill_i, word_i[WIDTH-1:1]};
        out_bit_o = word_i[0];
      end
      MODE_SRA: begin
        word_o    = {word_i[WIDTH-1], word_i[WIDTH-1:1]};
        out_bit_o = word_i[0];
      end
      MODE_ROL: begin
        word_o    = {word_i[WIDTH-2:0], word_i[WIDTH-1]};
        out_bit_o = word_i[WIDTH-1];
      end
      MODE_ROR: begin
        word_o    = {word_i[0], word_i[WIDTH-1:1]};
        out_bit_o = word_i[0];
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/universal_shift_reg.sv
// ============================================================================
// universal_shift_reg : iterative multi-mode shifter, one bit position per clock
// Optional feature    : USHIFT_STICKY_EN adds sticky_o (OR of all shifted-out bits)
// Revision            : 1.0
// ============================================================================
`default_nettype none

module universal_shift_reg
  import ushift_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [MODE_W-1:0]  mode_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               fill_i,
  input  logic [WIDTH-1:0]   data_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               carry_o
`ifdef USHIFT_STICKY_EN
  ,
  output logic               sticky_o
`endif
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               carry_q, carry_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic               fill_q, fill_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   step_word;
  logic               step_out;
  logic               capture;

  ushift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .word_i    (data_q),
    .mode_i    (mode_q),
    .fill_i    (fill_q),
    .word_o    (step_word),
    .out_bit_o (step_out)
  );

  // Start is only honoured once the previous operation has finished.
  assign capture = start_i && (state_q != ST_SHIFT);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;

    if (capture) begin
      data_d  = data_i;
      carry_d = 1'b0;
      mode_d  = mode_i;
      fill_d  = fill_i;
      cnt_d   = shamt_i;
      state_d = (is_load(mode_i) || (shamt_i == '0)) ? ST_DONE : ST_SHIFT;
    end else if (state_q == ST_SHIFT) begin
      data_d  = step_word;
      carry_d = step_out;
      cnt_d   = cnt_q - SHAMT_W'(1);
      if (cnt_q == SHAMT_W'(1)) begin
        state_d = ST_DONE;
      end
    end else begin
      state_d = ST_IDLE;
    end

    // Status flags come straight from flops, decoded one cycle early.
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      carry_q <= 1'b0;
      mode_q  <= MODE_SLL;
      fill_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_o  = data_q;
  assign carry_o = carry_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

`ifdef USHIFT_STICKY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (capture) begin
      sticky_d = 1'b0;
    end else if ((state_q == ST_SHIFT) && is_lossy(mode_q)) begin
      sticky_d = sticky_q | step_out;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_o = sticky_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
// ============================================================================
// tb_universal_shift_reg : randomized self-checking bench with behavioural model
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_universal_shift_reg;

  localparam int W  = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [SW-1:0] shamt = '0;
  logic          fill = 1'b0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  dout;
  logic          busy, done, carry;
`ifdef USHIFT_STICKY_EN
  logic          sticky;
`endif

  int n_vec = 0;
  int n_bad = 0;

  universal_shift_reg #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .mode_i   (mode),
    .shamt_i  (shamt),
    .fill_i   (fill),
    .data_i   (din),
    .data_o   (dout),
    .busy_o   (busy),
    .done_o   (done),
    .carry_o  (carry)
`ifdef USHIFT_STICKY_EN
    ,
    .sticky_o (sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Closed-form result of shifting d n times: no per-step iteration.
  function automatic void model(input logic [7:0] d, input logic [2:0] m, input int n,
                                input logic f, output logic [7:0] r, output logic c,
                                output logic s);
    logic [7:0] fw, ones, sel;
    int nn, k;
    r = d; c = 1'b0; s = 1'b0;
    if (m >= 3'd5 || n == 0) return;
    nn   = (n > 8) ? 8 : n;
    ones = 8'hFF;
    if (m == 3'd2) f = d[7];
    fw   = f ? 8'hFF : 8'h00;
    case (m)
      3'd0: begin
        if (n >= 8) r = fw;
        else        r = (d << n) | (fw >> (8 - n));
        c   = (n <= 8) ? d[8 - n] : f;
        sel = d >> (8 - nn);
        s   = (sel != 0) || (n > 8 && f);
      end
      3'd1, 3'd2: begin
        if (n >= 8) r = fw;
        else begin
          sel = fw << (8 - n);
          r   = (d >> n) | sel;
        end
        c   = (n <= 8) ? d[n - 1] : f;
        sel = d & (ones >> (8 - nn));
        s   = (sel != 0) || (n > 8 && f);
      end
      3'd3: begin
        k = n % 8;
        r = (k == 0) ? d : ((d << k) | (d >> (8 - k)));
        c = d[(8 - k) % 8];
      end
      default: begin
        k = n % 8;
        r = (k == 0) ? d : ((d >> k) | (d << (8 - k)));
        c = d[(n - 1) % 8];
      end
    endcase
  endfunction

  // Called at a negedge; returns at the done sample (b2b) or one idle cycle later.
  task automatic run_op(input logic [7:0] d, input logic [2:0] m, input int n, input logic f,
                        input bit noise, input bit b2b);
    logic [7:0] er;
    logic ec, es;
    int nexp, k, busy_seen;
    bit seen;
    model(d, m, n, f, er, ec, es);
    nexp = (m >= 3'd5) ? 0 : n;
    din = d; mode = m; shamt = SW'(n); fill = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0; busy_seen = 0; seen = 0;
    while (k <= 40) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busy_seen++;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        din   = 8'($urandom);
        mode  = 3'($urandom_range(0, 7));
        shamt = SW'($urandom_range(0, 15));
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(k), 32'(nexp));
    check("busy_cycles", 32'(busy_seen), 32'(nexp));
    check("busy_at_done", 32'(busy), 32'd0);
    check("data", 32'(dout), 32'(er));
    check("carry", 32'(carry), 32'(ec));
`ifdef USHIFT_STICKY_EN
    check("sticky", 32'(sticky), 32'(es));
`endif
    if (!b2b) begin
      @(negedge clk);
      check("done_pulse_1cyc", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_hold", 32'(dout), 32'(er));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_data", 32'(dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
`ifdef USHIFT_STICKY_EN
    check("rst_sticky", 32'(sticky), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_op(8'hAA, 3'd0, 1, 1'b0, 0, 0);
    check("sll_aa", 32'(dout), 32'h54);
    check("sll_aa_c", 32'(carry), 32'd1);
    run_op(8'h90, 3'd2, 3, 1'b0, 0, 0);
    check("sra_90", 32'(dout), 32'hF2);
    run_op(8'h90, 3'd1, 3, 1'b1, 0, 0);
    check("srl_90_f1", 32'(dout), 32'hF2);
    run_op(8'h90, 3'd1, 3, 1'b0, 0, 0);
    check("srl_90_f0", 32'(dout), 32'h12);
    run_op(8'hF0, 3'd3, 4, 1'b0, 0, 0);
    check("rol_f0", 32'(dout), 32'h0F);
    check("rol_f0_c", 32'(carry), 32'd1);
    run_op(8'h01, 3'd4, 9, 1'b0, 0, 0);
    check("ror_01", 32'(dout), 32'h80);
    run_op(8'h0F, 3'd0, 0, 1'b1, 0, 0);
    check("zero_shamt", 32'(dout), 32'h0F);
    run_op(8'h0F, 3'd5, 7, 1'b1, 0, 0);
    check("load", 32'(dout), 32'h0F);
    run_op(8'hC3, 3'd3, 7, 1'b0, 1, 0);
    run_op(8'h11, 3'd1, 2, 1'b0, 0, 1);
    run_op(8'h80, 3'd2, 9, 1'b0, 0, 0);
    run_op(8'h05, 3'd1, 2, 1'b0, 0, 0);
`ifdef USHIFT_STICKY_EN
    check("sticky_set", 32'(sticky), 32'd1);
`endif
    run_op(8'h04, 3'd1, 1, 1'b0, 0, 0);
`ifdef USHIFT_STICKY_EN
    check("sticky_clr", 32'(sticky), 32'd0);
`endif

    // Abort a long shift with an asynchronous reset between edges.
    din = 8'h81; mode = 3'd0; shamt = 4'd15; fill = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_data", 32'(dout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_carry", 32'(carry), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_abort_done", 32'(done), 32'd0);

    for (int i = 0; i < 60; i++) begin
      run_op(8'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 15),
             1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)));
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised, multi-mode, iterative shift register; successor to the fixed 8-bit left/right logical shifters.
- Captures a word on a start strobe, then shifts it one bit position per clock for a programmable count.
- Modes: logical left, logical right, arithmetic right, rotate left, rotate right, load.
- Reports busy/done and the last bit shifted out. Sits in datapaths that need variable shifts without a full barrel shifter.

Parameters:
- WIDTH, 8, data word width in bits (min 2)
- SHAMT_W, 4, width of the shift-amount input; max count 2^SHAMT_W-1

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  request; sampled only in IDLE or DONE
- mode_i  in  3  operation select, sampled with start_i
- shamt_i  in  SHAMT_W  shift count, sampled with start_i
- fill_i  in  1  bit shifted in for SLL/SRL, sampled with start_i
- data_i  in  WIDTH  operand, sampled with start_i
- data_o  out  WIDTH  working/result register
- busy_o  out  1  high while in SHIFT
- done_o  out  1  one-cycle pulse, result valid
- carry_o  out  1  last bit shifted or rotated out

Behaviour:
- Reset, asynchronous: state=IDLE; data_o=0; carry_o=0; busy_o=0; done_o=0; counter=0. Asserting rst_i mid-shift aborts the operation immediately. No done_o pulse follows.
- Mode encoding: 0=SLL, 1=SRL, 2=SRA, 3=ROL, 4=ROR, 5=LOAD. Codes 6 and 7 behave as LOAD.
- FSM states: IDLE, SHIFT, DONE.
- IDLE or DONE with start_i=1, at the capturing edge:
  - data_o<=data_i; carry_o<=0; mode, fill and count registered.
  - Next state is DONE if shamt_i==0 or mode is LOAD; otherwise SHIFT.
- SHIFT, each edge:
  - data_o moves one position per mode.
  - carry_o<=bit leaving the word: bit WIDTH-1 for SLL/ROL, bit 0 for SRL/SRA/ROR.
  - Counter decrements. When the counter was 1, next state is DONE.
- Fill rules:
  - SLL: fill enters bit 0. SRL: fill enters bit WIDTH-1.
  - SRA: MSB replicated.
  - ROL/ROR: the exiting bit wraps to the opposite end.
- DONE lasts exactly one cycle: done_o=1, busy_o=0. Next state is IDLE, or a new capture if start_i=1 (back-to-back operations, no bubble).
- Latency: start sampled at edge E0; done_o high during the cycle after edge E0+N, where N=shamt (N=0 for LOAD or zero shift).
- busy_o=1 exactly during the N SHIFT cycles.
- start_i during SHIFT is ignored; there is no queueing.
- shamt greater than or equal to WIDTH is legal and is not reduced modulo. The block shifts shamt times:
  - SLL/SRL saturate to all-fill.
  - SRA saturates to all-sign.
  - Rotates wrap naturally.
- data_o and carry_o hold their values in IDLE until the next capture.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro: USHIFT_STICKY_EN.
- When defined:
  - Adds output sticky_o (1 bit).
  - sticky_o clears to 0 on reset and on capture.
  - sticky_o ORs in every bit shifted out of the word during SLL/SRL/SRA; rotates leave it unchanged.
  - Used for rounding in right-shift normalisation.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package ushift_pkg holds:
  - Mode constants MODE_SLL..MODE_LOAD.
  - FSM state encodings ST_IDLE, ST_SHIFT, ST_DONE.
  - State width constant.
- One natural sub-module: ushift_step. It is combinational and performs a single one-position step.
  - Inputs: word, mode, fill.
  - Outputs: next word, out bit.
- universal_shift_reg owns the FSM, the counter and the registers.

Test Plan (WIDTH=8, SHAMT_W=4):
- SLL, data_i=10101010, shamt=1, fill=0 -> data_o=01010100, carry_o=1; done_o one cycle after the first shift edge; busy_o high exactly 1 cycle.
- SRA, data_i=10010000, shamt=3 -> data_o=11110010, carry_o=0, done after 3 busy cycles. SRL of the same value with fill=1 -> 11110010; with fill=0 -> 00010010.
- ROL, data_i=11110000, shamt=4 -> data_o=00001111, carry_o=1. ROR of 00000001, shamt=9 -> 10000000, carry_o=1.
- shamt=0 with SLL, and separately mode=5 (LOAD), data_i=00001111 -> data_o=00001111, busy_o never high, done_o pulses the cycle after capture.
- Start pulses during SHIFT are ignored and the result is unchanged. start_i held high in the DONE cycle captures the next operation with no idle bubble.
- Reset asserted mid-SHIFT, asynchronously between edges -> all outputs 0 immediately, no done_o pulse. With USHIFT_STICKY_EN, SRL of 00000101, shamt=2 -> sticky_o=1; shamt=1 of 00000100 -> sticky_o=0.
